// File: rtl/apb_pkg.sv
// Shared APB bus geometry, requester FSM encoding and the address alignment helper.
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ALIGNBITS  = 2;
  localparam int PROT_WIDTH = 3;

  typedef enum logic [1:0] {
    REQ_IDLE   = 2'd0,
    REQ_SETUP  = 2'd1,
    REQ_ACCESS = 2'd2
  } req_state_t;

  function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ALIGNBITS-1:0] == '0;
  endfunction

endpackage

// File: rtl/apb_requester.sv
// APB requester: one-entry command holding register, SETUP/ACCESS sequencing with
// back-to-back chaining, ACCESS watchdog and a registered valid/ready response port.
module apb_requester
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  // Both ports: a beat transfers on the rising edge where valid && ready; the
  // sender holds its payload stable while valid is high and ready is low.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [PROT_WIDTH-1:0] cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  output logic [PROT_WIDTH-1:0] pprot,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic [1:0]            dbg_state
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  req_state_t            r_state;
  logic                  r_hold_full;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic                  r_hold_write;
  logic [DATA_WIDTH-1:0] r_hold_wdata;
  logic [STRB_WIDTH-1:0] r_hold_strb;
  logic [PROT_WIDTH-1:0] r_hold_prot;
  logic [WD_W-1:0]       r_wd_cnt;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_slverr;
  logic                  r_rsp_timeout;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_WIDTH-1:0] r_pstrb;
  logic [PROT_WIDTH-1:0] r_pprot;

  logic w_rsp_free;
  logic w_aligned;
  logic w_complete;
  logic w_expire;
  logic w_deq_idle;
  logic w_deq_chain;
  logic w_deq;
  logic w_start;

  assign w_rsp_free = !r_rsp_valid || rsp_ready;
  assign w_aligned  = validAlign(r_hold_addr);
  assign w_complete = (r_state == REQ_ACCESS) && pready;
  // pready on the expiry cycle takes precedence, so expiry requires !pready.
  assign w_expire   = (TIMEOUT_CYCLES != 0) && (r_state == REQ_ACCESS) && !pready &&
                      (r_wd_cnt == WD_LAST);
  assign w_deq_idle = (r_state == REQ_IDLE) && r_hold_full && w_rsp_free;
  // Chaining produces a response next cycle while the bus keeps running, so it
  // needs the consumer ready now; otherwise the next transfer waits in IDLE.
  assign w_deq_chain = w_complete && r_hold_full && rsp_ready && w_aligned;
  assign w_deq       = w_deq_idle || w_deq_chain;
  assign w_start     = w_deq_chain || (w_deq_idle && w_aligned);

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_hold_full  <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_write <= 1'b0;
      r_hold_wdata <= '0;
      r_hold_strb  <= '0;
      r_hold_prot  <= '0;
    end else if (cmd_valid && !r_hold_full) begin
      r_hold_full  <= 1'b1;
      r_hold_addr  <= cmd_addr;
      r_hold_write <= cmd_write;
      r_hold_wdata <= cmd_wdata;
      r_hold_strb  <= cmd_strb;
      r_hold_prot  <= cmd_prot;
    end else if (w_deq) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= REQ_IDLE;
    end else begin
      case (r_state)
        REQ_IDLE:   if (w_start) r_state <= REQ_SETUP;
        REQ_SETUP:  r_state <= REQ_ACCESS;
        REQ_ACCESS: begin
          if (pready)        r_state <= w_start ? REQ_SETUP : REQ_IDLE;
          else if (w_expire) r_state <= REQ_IDLE;
        end
        default:    r_state <= REQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset || w_start)                         r_wd_cnt <= '0;
    else if ((r_state == REQ_ACCESS) && !pready)   r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
    end else if (w_start) begin
      r_psel    <= 1'b1;
      r_penable <= 1'b0;
      r_pwrite  <= r_hold_write;
      r_paddr   <= r_hold_addr;
      r_pwdata  <= r_hold_write ? r_hold_wdata : '0;
      r_pstrb   <= r_hold_write ? r_hold_strb : '0;
      r_pprot   <= r_hold_prot;
    end else if (r_state == REQ_SETUP) begin
      r_penable <= 1'b1;
    end else if (w_complete || w_expire) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_complete) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= (!r_pwrite && !pslverr) ? prdata : '0;
      r_rsp_slverr  <= pslverr;
      r_rsp_timeout <= 1'b0;
    end else if (w_expire) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b1;
      r_rsp_timeout <= 1'b1;
    end else if (w_deq_idle && !w_aligned) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b1;
      r_rsp_timeout <= 1'b0;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cmd_ready   = !r_hold_full;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: APB completer model, response scoreboard and
// protocol monitor around a linear sequence of transfer scenarios.
module tb_apb_requester;
  import apb_pkg::*;

  logic                  clk = 1'b0;
  logic                  preset = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr = '0;
  logic                  cmd_write = 1'b0;
  logic [DATA_WIDTH-1:0] cmd_wdata = '0;
  logic [STRB_WIDTH-1:0] cmd_strb = '0;
  logic [PROT_WIDTH-1:0] cmd_prot = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;
  logic                  psel, penable, pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [PROT_WIDTH-1:0] pprot;
  logic [DATA_WIDTH-1:0] prdata = '0;
  logic                  pready = 1'b0;
  logic                  pslverr = 1'b0;
  logic [1:0]            dbg_state;

  int errors = 0;
  int checks = 0;
  int rsp_cnt = 0;
  int psel_falls = 0;
  int wait_n = 0;
  bit hang = 1'b0;
  int acc_cnt = 0;

  logic [33:0]           exp_q[$];
  logic                  trace[$];
  logic [DATA_WIDTH-1:0] mem[16];
  logic [DATA_WIDTH-1:0] ref_mem[16];

  apb_requester #(.TIMEOUT_CYCLES(4)) dut (
    .pclk(clk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Completer model: decides pready/prdata at the negedge for the next rising edge.
  // Address 0x40 answers with PSLVERR; 'hang' withholds pready entirely.
  always @(negedge clk) begin
    if (psel && penable) begin
      if (!hang && acc_cnt >= wait_n) begin
        pready  = 1'b1;
        pslverr = (paddr[7:0] == 8'h40);
        if (pslverr) prdata = 32'hDEAD_BEEF;
        else if (pwrite) begin
          for (int b = 0; b < STRB_WIDTH; b++)
            if (pstrb[b]) mem[paddr[5:2]][b*8 +: 8] = pwdata[b*8 +: 8];
          prdata = $urandom;
        end else prdata = mem[paddr[5:2]];
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
    end
  end

  // Scoreboard: pop one expectation per accepted response.
  always @(negedge clk) begin
    logic [33:0] e;
    #1;
    if (!preset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 80'd1, 80'd0);
      else begin
        e = exp_q.pop_front();
        check("rsp", {46'd0, rsp_rdata, rsp_slverr, rsp_timeout}, {46'd0, e});
      end
      rsp_cnt++;
    end
  end

  // Bus monitor: penable trace while selected, psel falls, ACCESS stability, read zeroing.
  logic        prev_psel = 1'b0;
  logic        prev_wait = 1'b0;
  logic [71:0] saved = '0;
  always @(negedge clk) begin
    #1;
    if (psel) trace.push_back(penable);
    if (prev_psel && !psel) psel_falls++;
    if (psel && !pwrite) check("rd_wdata_zero", {44'd0, pwdata, pstrb}, 80'd0);
    if (psel && penable && prev_wait)
      check("access_stable", {8'd0, paddr, pwrite, pwdata, pstrb, pprot}, {8'd0, saved});
    prev_wait = psel && penable && !pready;
    saved     = {paddr, pwrite, pwdata, pstrb, pprot};
    prev_psel = psel;
  end

  // Reference model: expected {rdata, slverr, timeout} for a command.
  task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s);
    logic [33:0] e;
    if (a[1:0] != 2'b00)     e = {32'd0, 1'b1, 1'b0};
    else if (hang)           e = {32'd0, 1'b1, 1'b1};
    else if (a[7:0] == 8'h40) e = {32'd0, 1'b1, 1'b0};
    else if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
      e = 34'd0;
    end else e = {ref_mem[a[5:2]], 1'b0, 1'b0};
    exp_q.push_back(e);
  endtask

  // Driver: present a command, wait (bounded) for acceptance.
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    push_exp(a, w, d, s);
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("cmd_accept", {79'd0, cmd_ready}, 80'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 100) begin tick(); n++; end
    check("wait_rsp", {79'd0, (rsp_cnt >= target)}, 80'd1);
  endtask

  function automatic logic [15:0] pack_trace();
    logic [15:0] v = '0;
    foreach (trace[i]) v = {v[14:0], trace[i]};
    return v;
  endfunction

  initial begin
    logic [33:0] held;
    int n;
    int falls0;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // Reset state
    tick(); tick();
    check("rst_cmd_ready", {79'd0, cmd_ready}, 80'd1);
    check("rst_bus", {44'd0, psel, penable, pwrite, paddr, pstrb}, 80'd0);
    check("rst_rsp", {46'd0, rsp_valid, rsp_rdata, rsp_slverr}, 80'd0);
    check("rst_state", {78'd0, dbg_state}, {78'd0, REQ_IDLE});
    preset = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // 1: write 0x8, pready at first ACCESS, cycle-exact latency
    cmd_valid = 1'b1; cmd_addr = 32'h8; cmd_write = 1'b1;
    cmd_wdata = 32'hA5A5_A5A5; cmd_strb = 4'hF; cmd_prot = 3'd0;
    push_exp(32'h8, 1'b1, 32'hA5A5_A5A5, 4'hF);
    tick();
    cmd_valid = 1'b0;
    check("t1_c1_psel", {79'd0, psel}, 80'd0);
    tick();
    check("t1_c2_setup", {78'd0, psel, penable}, 80'b10);
    check("t1_c2_addr", {48'd0, paddr}, 80'h8);
    check("t1_c2_data", {44'd0, pwrite, pwdata, pstrb}, {44'd0, 1'b1, 32'hA5A5_A5A5, 4'hF});
    tick();
    check("t1_c3_access", {78'd0, psel, penable}, 80'b11);
    check("t1_c3_rspv", {79'd0, rsp_valid}, 80'd0);
    tick();
    check("t1_c4_rspv", {79'd0, rsp_valid}, 80'd1);
    check("t1_c4_idle", {78'd0, psel, penable}, 80'b00);
    wait_rsp(1);

    // 2: read 0x8 with 3 wait states
    wait_n = 3;
    trace.delete();
    send(32'h8, 1'b0, 32'h0, 4'h0, 3'd2);
    wait_rsp(2);
    check("t2_trace", {64'd0, pack_trace()}, 80'b01111);
    wait_n = 0;

    // 3: back-to-back write/read with partial strobes; psel must not drop between
    trace.delete();
    falls0 = psel_falls;
    send(32'hC, 1'b1, 32'h1122_3344, 4'h3, 3'd1);
    send(32'hC, 1'b0, 32'h0, 4'h0, 3'd5);
    wait_rsp(4);
    check("t3_trace_len", 80'(trace.size()), 80'd4);
    check("t3_trace", {64'd0, pack_trace()}, 80'b0101);
    check("t3_psel_falls", 80'(psel_falls - falls0), 80'd1);

    // 4: misaligned read, then completer-error write/read
    trace.delete();
    send(32'h6, 1'b0, 32'h0, 4'h0, 3'd0);
    wait_rsp(5);
    check("t4_no_psel", 80'(trace.size()), 80'd0);
    send(32'h40, 1'b1, 32'h5555_AAAA, 4'hF, 3'd0);
    send(32'h40, 1'b0, 32'h0, 4'h0, 3'd0);
    wait_rsp(7);

    // 5: watchdog expiry after 4 ACCESS cycles
    hang = 1'b1;
    trace.delete();
    send(32'h10, 1'b0, 32'h0, 4'h0, 3'd0);
    wait_rsp(8);
    check("t5_trace", {64'd0, pack_trace()}, 80'b01111);
    check("t5_psel_off", {78'd0, psel, penable}, 80'b00);
    hang = 1'b0;

    // 6: response held blocks the next transfer; reset mid-ACCESS
    rsp_ready = 1'b0;
    send(32'h8, 1'b0, 32'h0, 4'h0, 3'd0);
    send(32'h10, 1'b0, 32'h0, 4'h0, 3'd0);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check("t6_rspv", {79'd0, rsp_valid}, 80'd1);
    held = {rsp_rdata, rsp_slverr, rsp_timeout};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_setup", {79'd0, psel}, 80'd0);
      check("t6_rsp_held", {45'd0, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout},
            {45'd0, 1'b1, held});
    end
    check("t6_cmd_ready", {79'd0, cmd_ready}, 80'd0);
    hang = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    while (!(psel && penable) && n < 50) begin tick(); n++; end
    check("t6_access", {78'd0, psel, penable}, 80'b11);
    check("t6_one_pending", 80'(exp_q.size()), 80'd1);
    preset = 1'b1;
    tick();
    check("t6_rst_bus", {78'd0, psel, penable}, 80'b00);
    check("t6_rst_rsp", {79'd0, rsp_valid}, 80'd0);
    check("t6_rst_cmd_ready", {79'd0, cmd_ready}, 80'd1);
    check("t6_rst_state", {78'd0, dbg_state}, {78'd0, REQ_IDLE});
    exp_q.delete();
    hang = 1'b0;
    preset = 1'b0;
    tick();

    // Post-reset transfers still work and data written earlier is intact
    n = rsp_cnt;
    send(32'hC, 1'b0, 32'h0, 4'h0, 3'd0);
    send(32'h8, 1'b0, 32'h0, 4'h0, 3'd0);
    wait_rsp(n + 2);
    check("final_drained", 80'(exp_q.size()), 80'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
